if_fetch_ctrl: RTL

- Front end of the RV32IM pipeline IF stage: owns the program counter, drives the address into the instruction memory, and captures the returned word into the IF/ID pipeline register.
- The instruction memory samples `pc_out` on the falling clock edge. Its `instruction` is stable before the next rising edge, so the fetch-to-capture latency is one cycle.
- Handles hazard-unit stalls, branch/jump redirects with flush, post-reset boot bubble, misaligned-target fault, and fetch/bubble performance counters.

---
 rtl/if_fetch_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - IF stage front end: PC ownership, IF/ID capture, stall/redirect/flush, boot bubble, fault, perf counters.
// Instruction memory samples pc_out on the falling edge, so the word on `instruction` belongs to the current pc_out.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  input  logic [31:0]      instruction,
  output logic [31:0]      pc_out,
  output logic [31:0]      ifid_pc,
  output logic [31:0]      ifid_pc_plus4,
  output logic [31:0]      ifid_instr,
  output logic             ifid_valid,
  output logic             fetch_fault,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t           r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_ifid_pc;
  logic [31:0]      r_ifid_pc_plus4;
  logic [31:0]      r_ifid_instr;
  logic             r_ifid_valid;
  logic             r_fetch_fault;
  logic [CNT_W-1:0] r_fetch_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  logic             w_misaligned;
  assign w_misaligned = (redirect_target[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_BOOT;
      r_pc            <= RESET_PC;
      r_ifid_pc       <= 32'h0000_0000;
      r_ifid_pc_plus4 <= 32'h0000_0004;
      r_ifid_instr    <= NOP_INSTR;
      r_ifid_valid    <= 1'b0;
      r_fetch_fault   <= 1'b0;
      r_fetch_cnt     <= '0;
      r_bubble_cnt    <= '0;
    end else begin
      case (r_state)
        // Memory output right after reset may still be stale, so insert one bubble.
        ST_BOOT: begin
          r_ifid_instr <= NOP_INSTR;
          r_ifid_valid <= 1'b0;
          r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
          r_state      <= ST_RUN;
        end
        ST_RUN: begin
          if (redirect_valid && w_misaligned) begin
            r_state       <= ST_FAULT;
            r_fetch_fault <= 1'b1;
            r_ifid_instr  <= NOP_INSTR;
            r_ifid_valid  <= 1'b0;
            r_bubble_cnt  <= r_bubble_cnt + CNT_W'(1);
          end else if (redirect_valid) begin
            // The word on `instruction` is wrong-path; flush it and overrule any stall.
            r_pc         <= {redirect_target[31:2], 2'b00};
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
          end else if (!stall) begin
            r_ifid_pc       <= r_pc;
            r_ifid_pc_plus4 <= r_pc + 32'd4;
            r_ifid_instr    <= instruction;
            r_ifid_valid    <= 1'b1;
            r_pc            <= r_pc + 32'd4;
            r_fetch_cnt     <= r_fetch_cnt + CNT_W'(1);
          end
        end
        ST_FAULT: begin
          r_ifid_instr <= NOP_INSTR;
          r_ifid_valid <= 1'b0;
        end
        default: begin
          r_state       <= ST_FAULT;
          r_fetch_fault <= 1'b1;
          r_ifid_instr  <= NOP_INSTR;
          r_ifid_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign pc_out        = r_pc;
  assign ifid_pc       = r_ifid_pc;
  assign ifid_pc_plus4 = r_ifid_pc_plus4;
  assign ifid_instr    = r_ifid_instr;
  assign ifid_valid    = r_ifid_valid;
  assign fetch_fault   = r_fetch_fault;
  assign fetch_cnt     = r_fetch_cnt;
  assign bubble_cnt    = r_bubble_cnt;

endmodule
